regfile_writeback: RTL and testbench

Writeback stage feeding the register file write port (`rw_dest`, `rw_data`, `rw_en`). It merges single-cycle ALU results with multi-cycle load responses: load data is extracted and sign/zero-extended, buffered in a small FIFO, and committed when the port is free, with ALU results taking priority. A per-register busy scoreboard tracks outstanding loads so the issue stage can stall on load-use hazards.

---
 rtl/regfile_writeback.sv | 157 +++++++++++++++
 tb/tb_regfile_writeback.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Writeback stage: merges ALU results with buffered, extended load responses onto
// the register file write port and tracks outstanding loads in a busy scoreboard.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_stall,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  output logic [31:0] busy,
  output logic        err,
  output logic [4:0]  rw_dest,
  output logic [31:0] rw_data,
  output logic        rw_en
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      mem_q [DEPTH];
  entry_t      mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [31:0] busy_q, busy_d;
  logic        err_q, err_d;
  logic [4:0]  rw_dest_q, rw_dest_d;
  logic [31:0] rw_data_q, rw_data_d;
  logic        rw_en_q, rw_en_d;
  logic        rw_ld_q, rw_ld_d;

  logic        fifo_empty, fifo_full;
  logic        push, pop;
  entry_t      head;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Extraction of the addressed byte/half and sign or zero extension.
  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_data[7:0];
      2'd1:    ld_byte = ld_data[15:8];
      2'd2:    ld_byte = ld_data[23:16];
      default: ld_byte = ld_data[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
    case (ld_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = ld_data;
    endcase
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ld_ready   = !fifo_full && !rst;
  assign push       = ld_valid && ld_ready;
  assign pop        = !alu_valid && !fifo_empty;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign iss_stall  = (iss_rd != 5'd0) && busy_q[iss_rd];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{rd: ld_rd, data: ld_ext};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // ALU wins the port; an rd==0 selection is consumed without a write.
  always_comb begin
    rw_en_d   = 1'b0;
    rw_ld_d   = 1'b0;
    rw_dest_d = 5'd0;
    rw_data_d = 32'h0;
    if (alu_valid) begin
      rw_en_d   = (alu_rd != 5'd0);
      rw_dest_d = alu_rd;
      rw_data_d = alu_data;
    end else if (pop) begin
      rw_en_d   = (head.rd != 5'd0);
      rw_ld_d   = (head.rd != 5'd0);
      rw_dest_d = head.rd;
      rw_data_d = head.data;
    end
  end

  // Clear follows the registered load write; a same-cycle issue overrides it.
  always_comb begin
    busy_d = busy_q;
    if (rw_en_q && rw_ld_q) begin
      busy_d[rw_dest_q] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    err_d = err_q || (ld_valid && !ld_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      busy_q    <= 32'h0;
      err_q     <= 1'b0;
      rw_dest_q <= 5'd0;
      rw_data_q <= 32'h0;
      rw_en_q   <= 1'b0;
      rw_ld_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      rw_dest_q <= rw_dest_d;
      rw_data_q <= rw_data_d;
      rw_en_q   <= rw_en_d;
      rw_ld_q   <= rw_ld_d;
    end
  end

  // Storage needs no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy    = busy_q;
  assign err     = err_q;
  assign rw_dest = rw_dest_q;
  assign rw_data = rw_data_q;
  assign rw_en   = rw_en_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: extraction vector table plus hand-written
// sequences for scoreboard, priority/overflow and reset-mid-drain corners.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_stall;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] busy;
  logic        err;
  logic [4:0]  rw_dest;
  logic [31:0] rw_data;
  logic        rw_en;

  int checks = 0;
  int errors = 0;

  regfile_writeback #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .busy(busy), .err(err),
    .rw_dest(rw_dest), .rw_data(rw_data), .rw_en(rw_en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    iss_valid = 0; iss_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; ld_funct3 = 3'b010; ld_addr_lo = 0;
  endtask

  initial begin
    vecs[0] = '{3'b000, 2'd0, 5'd3, 32'h8001_7F80, 32'hFFFF_FF80};
    vecs[1] = '{3'b100, 2'd0, 5'd4, 32'h8001_7F80, 32'h0000_0080};
    vecs[2] = '{3'b000, 2'd1, 5'd5, 32'h8001_7F80, 32'h0000_007F};
    vecs[3] = '{3'b001, 2'd2, 5'd6, 32'h8001_7F80, 32'hFFFF_8001};
    vecs[4] = '{3'b101, 2'd2, 5'd8, 32'h8001_7F80, 32'h0000_8001};
    vecs[5] = '{3'b010, 2'd3, 5'd9, 32'h8001_7F80, 32'h8001_7F80};
    vecs[6] = '{3'b001, 2'd1, 5'd10, 32'h8001_7F80, 32'h0000_7F80};
    vecs[7] = '{3'b011, 2'd2, 5'd11, 32'h1234_5678, 32'h1234_5678};

    clear_inputs();
    rst = 1;
    tick();
    tick();
    chk("ld_ready_in_reset", {31'h0, ld_ready}, 32'h0);
    rst = 0;
    tick();
    chk("reset_rw_en", {31'h0, rw_en}, 32'h0);
    chk("reset_busy", busy, 32'h0);
    chk("reset_ld_ready", {31'h0, ld_ready}, 32'h1);
    chk("reset_err", {31'h0, err}, 32'h0);

    // ALU path, one cycle latency
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 0;
    chk("alu_rw_en", {31'h0, rw_en}, 32'h1);
    chk("alu_rw_dest", {27'h0, rw_dest}, 32'd5);
    chk("alu_rw_data", rw_data, 32'hDEADBEEF);
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1111_2222;
    tick();
    alu_valid = 0;
    chk("alu_rd0_rw_en", {31'h0, rw_en}, 32'h0);
    tick();

    // Load extraction table
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1; ld_rd = vecs[i].rd; ld_data = vecs[i].data;
      ld_funct3 = vecs[i].f3; ld_addr_lo = vecs[i].lo;
      tick();
      ld_valid = 0;
      chk($sformatf("ext%0d_no_fallthrough", i), {31'h0, rw_en}, 32'h0);
      tick();
      chk($sformatf("ext%0d_rw_en", i), {31'h0, rw_en}, 32'h1);
      chk($sformatf("ext%0d_rw_dest", i), {27'h0, rw_dest}, {27'h0, vecs[i].rd});
      chk($sformatf("ext%0d_rw_data", i), rw_data, vecs[i].exp);
    end
    tick();

    // Scoreboard: issue, stall, response, clear
    iss_valid = 1; iss_rd = 7;
    tick();
    iss_valid = 0;
    chk("sb_busy7_set", busy, 32'h0000_0080);
    chk("sb_stall7", {31'h0, iss_stall}, 32'h1);
    iss_rd = 6;
    #1;
    chk("sb_stall6", {31'h0, iss_stall}, 32'h0);
    iss_rd = 0;
    ld_valid = 1; ld_rd = 7; ld_data = 32'hCAFE_F00D; ld_funct3 = 3'b010; ld_addr_lo = 0;
    tick();
    ld_valid = 0;
    chk("sb_n1_rw_en", {31'h0, rw_en}, 32'h0);
    tick();
    chk("sb_n2_rw_en", {31'h0, rw_en}, 32'h1);
    chk("sb_n2_rw_dest", {27'h0, rw_dest}, 32'd7);
    chk("sb_n2_busy_still", busy, 32'h0000_0080);
    tick();
    chk("sb_n3_busy_clear", busy, 32'h0);

    // Same-cycle clear and reissue to rd 7: set wins
    iss_valid = 1; iss_rd = 7;
    tick();
    iss_valid = 0;
    ld_valid = 1; ld_rd = 7; ld_data = 32'h0000_0042;
    tick();
    ld_valid = 0;
    tick();
    chk("sb_race_rw_en", {31'h0, rw_en}, 32'h1);
    iss_valid = 1; iss_rd = 7;
    tick();
    iss_valid = 0; iss_rd = 0;
    chk("sb_race_busy7", busy, 32'h0000_0080);

    // Priority and overflow: ALU held high while loads fill the FIFO
    alu_valid = 1; alu_rd = 1; alu_data = 32'h0000_00AA;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = 5'(10 + i); ld_data = 32'h100 + 32'(i); ld_funct3 = 3'b010;
      tick();
    end
    ld_valid = 0;
    chk("ovf_alu_rw_dest", {27'h0, rw_dest}, 32'd1);
    chk("ovf_full_ready", {31'h0, ld_ready}, 32'h0);
    chk("ovf_err_before", {31'h0, err}, 32'h0);
    ld_valid = 1; ld_rd = 20; ld_data = 32'hBAD0_BAD0;
    tick();
    ld_valid = 0;
    chk("ovf_err_set", {31'h0, err}, 32'h1);
    alu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("drain%0d_rw_en", i), {31'h0, rw_en}, 32'h1);
      chk($sformatf("drain%0d_rw_dest", i), {27'h0, rw_dest}, 32'(10 + i));
      chk($sformatf("drain%0d_rw_data", i), rw_data, 32'h100 + 32'(i));
      if (i == 0) chk("drain_ready_back", {31'h0, ld_ready}, 32'h1);
    end
    tick();
    chk("drain_done_rw_en", {31'h0, rw_en}, 32'h0);
    chk("err_sticky", {31'h0, err}, 32'h1);

    // Reset mid-drain with three entries queued
    alu_valid = 1; alu_rd = 2; alu_data = 32'h55;
    iss_valid = 1; iss_rd = 20;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_rd = 5'(21 + i); ld_data = 32'h200 + 32'(i);
      tick();
      iss_valid = 0;
    end
    ld_valid = 0;
    alu_valid = 0;
    rst = 1;
    tick();
    chk("rstmid_rw_en", {31'h0, rw_en}, 32'h0);
    chk("rstmid_busy", busy, 32'h0);
    chk("rstmid_err", {31'h0, err}, 32'h0);
    chk("rstmid_ready_low", {31'h0, ld_ready}, 32'h0);
    rst = 0;
    #1;
    chk("rstmid_ready_high", {31'h0, ld_ready}, 32'h1);
    tick();
    chk("rstmid_empty1", {31'h0, rw_en}, 32'h0);
    tick();
    chk("rstmid_empty2", {31'h0, rw_en}, 32'h0);
    chk("rstmid_dest", {27'h0, rw_dest}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
